// File: rtl/rf_rx_pkg.sv
// Shared constants and types for the RF receive framer.
// Default sync signature, packet geometry and the framer state type.
package rf_rx_pkg;

    localparam int PKT_W   = 64;
    localparam int BYTE_W  = 8;
    localparam int N_BYTES = PKT_W / BYTE_W;
    localparam int IDX_W   = $clog2(N_BYTES);
    localparam int CNT_W   = 7;

    localparam logic [PKT_W-1:0] SYNC_MASK_DEF = 64'h7C00_001F_0000_0174;
    localparam logic [PKT_W-1:0] SYNC_VAL_DEF  = 64'h7C00_001F_0000_0174;

    typedef enum logic {
        HUNT   = 1'b0,
        STREAM = 1'b1
    } rx_state_t;

    function automatic logic sync_hit(
        input logic [PKT_W-1:0] window,
        input logic [PKT_W-1:0] mask,
        input logic [PKT_W-1:0] val
    );
        return (window & mask) == val;
    endfunction

endpackage

// File: rtl/rf_bit_sampler.sv
// Bit-window sampler: latches any rfin pulse in a window and shifts it in on sh_en.
// clr wipes everything (receiver disabled); rearm restarts the hunt after a match.
module rf_bit_sampler
    import rf_rx_pkg::*;
#(
    parameter int MIN_BITS = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rfin,
    input  logic             sh_en,
    input  logic             clr,
    input  logic             rearm,
    output logic [PKT_W-1:0] shreg,
    output logic             full
);

    localparam logic [CNT_W-1:0] MIN_CNT = CNT_W'(MIN_BITS);

    logic             bit_l_reg;
    logic [PKT_W-1:0] shreg_reg;
    logic [CNT_W-1:0] bitcnt_reg;

    // A pulse landing on the closing strobe still belongs to the closing bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_l_reg <= 1'b0;
        end else if (clr || sh_en) begin
            bit_l_reg <= 1'b0;
        end else if (rfin) begin
            bit_l_reg <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_reg  <= '0;
            bitcnt_reg <= '0;
        end else if (clr || rearm) begin
            shreg_reg  <= '0;
            bitcnt_reg <= '0;
        end else if (sh_en) begin
            shreg_reg <= {shreg_reg[PKT_W-2:0], bit_l_reg | rfin};
            if (bitcnt_reg < MIN_CNT) begin
                bitcnt_reg <= bitcnt_reg + 1'b1;
            end
        end
    end

    assign shreg = shreg_reg;
    assign full  = (bitcnt_reg >= MIN_CNT);

endmodule

// File: rtl/rf_pkt_sync_rx.sv
// RF receive framer: hunts for the sync signature, freezes the frame and
// streams it MSB-first as bytes over a valid/ready handshake.
module rf_pkt_sync_rx
    import rf_rx_pkg::*;
#(
    parameter logic [PKT_W-1:0] SYNC_MASK = SYNC_MASK_DEF,
    parameter logic [PKT_W-1:0] SYNC_VAL  = SYNC_VAL_DEF,
    parameter int               MIN_BITS  = 64
) (
    input  logic              i_PCLK,
    input  logic              i_PRESETn,
    input  logic              rfin,
    input  logic              sh_en,
    input  logic              RX,
    input  logic              i_byte_ready,
    input  logic              i_ovr_clr,
    output logic [BYTE_W-1:0] o_byte,
    output logic              o_byte_valid,
    output logic              pkt_rec,
    output logic [PKT_W-1:0]  o_pkt,
    output logic              o_ovr
);

    rx_state_t        state_reg, state_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic [PKT_W-1:0] pkt_reg, pkt_next;
    logic             ovr_reg, ovr_next;

    logic [PKT_W-1:0] shreg;
    logic             full;
    logic             match;
    logic             ovr_set;
    logic             smp_clr;
    logic             smp_rearm;
    logic             streaming;

    logic [BYTE_W-1:0] byte_lane [N_BYTES];

    rf_bit_sampler #(
        .MIN_BITS (MIN_BITS)
    ) u_sampler (
        .clk   (i_PCLK),
        .rst_n (i_PRESETn),
        .rfin  (rfin),
        .sh_en (sh_en),
        .clr   (smp_clr),
        .rearm (smp_rearm),
        .shreg (shreg),
        .full  (full)
    );

    // Lane 0 is the most significant byte of the frozen frame.
    genvar gi;
    generate
        for (gi = 0; gi < N_BYTES; gi++) begin : g_lane
            assign byte_lane[gi] = pkt_reg[PKT_W-1-BYTE_W*gi -: BYTE_W];
        end
    endgenerate

    assign match     = sync_hit(shreg, SYNC_MASK, SYNC_VAL) && full;
    assign streaming = (state_reg == STREAM);

    always_ff @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            state_reg <= HUNT;
            idx_reg   <= '0;
            pkt_reg   <= '0;
            ovr_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            pkt_reg   <= pkt_next;
            ovr_reg   <= ovr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        pkt_next   = pkt_reg;
        ovr_set    = 1'b0;
        smp_clr    = ~RX;
        smp_rearm  = 1'b0;

        if (!RX) begin
            // Disabling the receiver drops the stream but keeps pkt and the overrun flag.
            state_next = HUNT;
            idx_next   = '0;
        end else begin
            unique case (state_reg)
                HUNT: begin
                    if (match) begin
                        state_next = STREAM;
                        idx_next   = '0;
                        pkt_next   = shreg;
                        smp_rearm  = 1'b1;
                    end
                end
                STREAM: begin
                    if (i_byte_ready) begin
                        if (idx_reg == IDX_W'(N_BYTES - 1)) begin
                            state_next = HUNT;
                            idx_next   = '0;
                        end else begin
                            idx_next = idx_reg + 1'b1;
                        end
                    end
                    // A frame arriving while one is still held is counted, not kept.
                    if (match) begin
                        ovr_set   = 1'b1;
                        smp_rearm = 1'b1;
                    end
                end
                default: begin
                    state_next = HUNT;
                    idx_next   = '0;
                end
            endcase
        end

        ovr_next = ovr_set | (ovr_reg & ~i_ovr_clr);
    end

    assign pkt_rec      = streaming;
    assign o_byte_valid = streaming;
    assign o_byte       = streaming ? byte_lane[idx_reg] : '0;
    assign o_pkt        = pkt_reg;
    assign o_ovr        = ovr_reg;

endmodule

// File: tb/tb_rf_pkt_sync_rx.sv
// Self-checking bench for rf_pkt_sync_rx: a queue-based reference model is
// compared every cycle, plus literal expectations for the key scenarios.
module tb_rf_pkt_sync_rx;

    localparam logic [63:0] SYNC = 64'h7C00_001F_0000_0174;
    localparam logic [63:0] MASK = 64'h7C00_001F_0000_0174;
    localparam int          MINB = 64;

    logic        i_PCLK = 1'b0;
    logic        i_PRESETn = 1'b0;
    logic        rfin = 1'b0;
    logic        sh_en = 1'b0;
    logic        RX = 1'b0;
    logic        i_byte_ready = 1'b0;
    logic        i_ovr_clr = 1'b0;
    logic [7:0]  o_byte;
    logic        o_byte_valid;
    logic        pkt_rec;
    logic [63:0] o_pkt;
    logic        o_ovr;

    int checks = 0;
    int failures = 0;

    rf_pkt_sync_rx dut (
        .i_PCLK       (i_PCLK),
        .i_PRESETn    (i_PRESETn),
        .rfin         (rfin),
        .sh_en        (sh_en),
        .RX           (RX),
        .i_byte_ready (i_byte_ready),
        .i_ovr_clr    (i_ovr_clr),
        .o_byte       (o_byte),
        .o_byte_valid (o_byte_valid),
        .pkt_rec      (pkt_rec),
        .o_pkt        (o_pkt),
        .o_ovr        (o_ovr)
    );

    always #5 i_PCLK = ~i_PCLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference model: bits since the last clear, a pending-pulse flag and
    // the queue of packet bytes still to be delivered.
    bit          m_q[$];
    logic        m_pend = 1'b0;
    logic [7:0]  m_bytes[$];
    logic [63:0] m_pkt = '0;
    logic        m_ovr = 1'b0;
    logic [63:0] m_cur;
    logic        m_hit, m_held, m_set;

    function automatic logic [63:0] window();
        logic [63:0] v;
        v = '0;
        foreach (m_q[i]) v = {v[62:0], m_q[i]};
        return v;
    endfunction

    always @(posedge i_PCLK or negedge i_PRESETn) begin
        if (!i_PRESETn) begin
            m_q.delete();
            m_bytes.delete();
            m_pend = 1'b0;
            m_pkt  = '0;
            m_ovr  = 1'b0;
        end else begin
            m_cur = window();
            m_hit = (m_q.size() >= MINB) && ((m_cur & MASK) == SYNC);
            m_set = 1'b0;
            if (!RX) begin
                m_q.delete();
                m_bytes.delete();
                m_pend = 1'b0;
            end else begin
                m_held = (m_bytes.size() > 0);
                if (m_held && i_byte_ready) void'(m_bytes.pop_front());
                if (m_hit) begin
                    if (m_held) m_set = 1'b1;
                    else begin
                        m_pkt = m_cur;
                        for (int b = 0; b < 8; b++) m_bytes.push_back(m_cur[63-8*b -: 8]);
                    end
                    m_q.delete();
                end else if (sh_en) begin
                    m_q.push_back(m_pend | rfin);
                    if (m_q.size() > 64) void'(m_q.pop_front());
                end
                if (sh_en) m_pend = 1'b0;
                else if (rfin) m_pend = 1'b1;
            end
            if (m_set) m_ovr = 1'b1;
            else if (i_ovr_clr) m_ovr = 1'b0;
        end
    end

    always @(negedge i_PCLK) begin
        logic e_valid;
        logic [7:0] e_byte;
        e_valid = (m_bytes.size() > 0);
        e_byte  = e_valid ? m_bytes[0] : 8'h00;
        chk("m_valid", 64'(o_byte_valid), 64'(e_valid));
        chk("m_pkt_rec", 64'(pkt_rec), 64'(e_valid));
        chk("m_byte", 64'(o_byte), 64'(e_byte));
        chk("m_o_pkt", o_pkt, m_pkt);
        chk("m_ovr", 64'(o_ovr), 64'(m_ovr));
    end

    // Stimulus helpers
    int         ready_mode = 0;  // 0 always, 1 toggling, 2 stalled, 3 random
    bit         rand_oc = 1'b0;
    int         cyc = 0;
    logic [7:0] acc[$];
    logic [7:0] exp_bytes [8];

    task automatic tick(input logic r, input logic s, input logic oc);
        @(negedge i_PCLK);
        rfin  = r;
        sh_en = s;
        i_ovr_clr = oc | (rand_oc && ($urandom_range(0, 15) == 0));
        cyc++;
        case (ready_mode)
            0:       i_byte_ready = 1'b1;
            1:       i_byte_ready = cyc[0];
            2:       i_byte_ready = 1'b0;
            default: i_byte_ready = 1'($urandom_range(0, 1));
        endcase
        #1;
        if (o_byte_valid && i_byte_ready) acc.push_back(o_byte);
    endtask

    // pos: cycle of the window carrying the pulse; cycle 2 coincides with sh_en.
    task automatic send_bit(input logic b, input int pos);
        for (int c = 0; c < 4; c++) tick(b && (c == pos), c == 2, 1'b0);
    endtask

    task automatic send_bits(input logic [63:0] v, input int n, input int pos);
        for (int i = n - 1; i >= 0; i--)
            send_bit(v[i], (pos < 0) ? int'($urandom_range(0, 2)) : pos);
    endtask

    task automatic rx_gap();
        RX = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        RX = 1'b1;
    endtask

    task automatic drain(input int limit, output int k);
        k = 0;
        while (pkt_rec && k < limit) begin
            tick(1'b0, 1'b0, 1'b0);
            k++;
        end
        chk("drain_bounded", 64'(pkt_rec), 64'd0);
    endtask

    task automatic check_acc(input string tag);
        chk({tag, "_count"}, 64'(acc.size()), 64'd8);
        for (int i = 0; i < 8; i++)
            if (i < acc.size()) chk($sformatf("%s_byte%0d", tag, i), 64'(acc[i]), 64'(exp_bytes[i]));
    endtask

    initial begin
        int k;
        logic [63:0] f;
        int kind;
        exp_bytes = '{8'h7C, 8'h00, 8'h00, 8'h1F, 8'h00, 8'h00, 8'h01, 8'h74};

        // Reset values
        tick(1'b0, 1'b0, 1'b0);
        chk("rst_byte", 64'(o_byte), 64'd0);
        chk("rst_valid", 64'(o_byte_valid), 64'd0);
        chk("rst_pkt_rec", 64'(pkt_rec), 64'd0);
        chk("rst_o_pkt", o_pkt, 64'd0);
        chk("rst_ovr", 64'(o_ovr), 64'd0);
        i_PRESETn = 1'b1;
        RX = 1'b1;

        // Capture and drain, every 1-bit pulsed in the sh_en cycle
        ready_mode = 0;
        send_bits(SYNC >> 1, 63, 2);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("cap_pkt_rec_early", 64'(pkt_rec), 64'd0);
        acc.delete();
        tick(1'b0, 1'b0, 1'b0);
        chk("cap_pkt_rec", 64'(pkt_rec), 64'd1);
        chk("cap_byte0", 64'(o_byte), 64'h7C);
        drain(50, k);
        chk("cap_drain_cycles", 64'(k), 64'd8);
        check_acc("cap");
        chk("cap_o_pkt", o_pkt, SYNC);

        // Backpressure with noise bits ahead of the frame
        rx_gap();
        ready_mode = 1;
        acc.delete();
        send_bits(64'($urandom_range(0, 511)), 9, -1);
        send_bits(SYNC, 64, -1);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        drain(100, k);
        check_acc("bp");

        // Near misses: bit 32 cleared, then only 63 bits after RX rises
        rx_gap();
        ready_mode = 2;
        send_bits(SYNC & ~(64'd1 << 32), 64, -1);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("nm32_pkt_rec", 64'(pkt_rec), 64'd0);
        rx_gap();
        send_bits(SYNC, 63, -1);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("nm63_pkt_rec", 64'(pkt_rec), 64'd0);
        chk("nm_ovr", 64'(o_ovr), 64'd0);

        // Overrun while stalled, then clear
        rx_gap();
        send_bits(SYNC, 64, -1);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("ovr_first_pkt_rec", 64'(pkt_rec), 64'd1);
        send_bits(SYNC | 64'h1, 64, -1);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("ovr_set", 64'(o_ovr), 64'd1);
        chk("ovr_o_pkt", o_pkt, SYNC);
        chk("ovr_byte_held", 64'(o_byte), 64'h7C);
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 1'b0);
        chk("ovr_clr", 64'(o_ovr), 64'd0);

        // RX dropped mid-stream
        RX = 1'b0;
        tick(1'b0, 1'b0, 1'b0);
        chk("rxdrop_valid", 64'(o_byte_valid), 64'd0);
        chk("rxdrop_o_pkt", o_pkt, SYNC);
        RX = 1'b1;

        // Randomised frames, ready and overrun clears against the model
        ready_mode = 3;
        rand_oc = 1'b1;
        for (int it = 0; it < 8; it++) begin
            if ($urandom_range(0, 1) == 1) rx_gap();
            kind = int'($urandom_range(0, 2));
            f = ({$urandom, $urandom} & ~MASK) | SYNC;
            if (kind == 1) f = f & ~(64'd1 << 32);
            if (kind == 2) f = {$urandom, $urandom};
            send_bits(64'({$urandom, $urandom}), int'($urandom_range(0, 20)), -1);
            send_bits(f, 64, -1);
            tick(1'b0, 1'b0, 1'b0);
            tick(1'b0, 1'b0, 1'b0);
            if ($urandom_range(0, 2) != 0) drain(400, k);
        end
        rand_oc = 1'b0;

        // Asynchronous reset mid-stream
        rx_gap();
        ready_mode = 2;
        send_bits(SYNC, 64, -1);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("ar_pre_pkt_rec", 64'(pkt_rec), 64'd1);
        @(negedge i_PCLK);
        #2 i_PRESETn = 1'b0;
        #1;
        chk("ar_byte", 64'(o_byte), 64'd0);
        chk("ar_valid", 64'(o_byte_valid), 64'd0);
        chk("ar_pkt_rec", 64'(pkt_rec), 64'd0);
        chk("ar_o_pkt", o_pkt, 64'd0);
        chk("ar_ovr", 64'(o_ovr), 64'd0);
        tick(1'b0, 1'b0, 1'b0);
        i_PRESETn = 1'b1;
        send_bits(SYNC, 63, -1);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("ar_63_pkt_rec", 64'(pkt_rec), 64'd0);
        send_bits(SYNC, 64, -1);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        chk("ar_recap_pkt_rec", 64'(pkt_rec), 64'd1);
        chk("ar_recap_o_pkt", o_pkt, SYNC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
